jk_cmd_sequencer: RTL
=====================

Name: jk_cmd_sequencer

Overview:
- Upstream driver for the JK flip-flop stage.
- Accepts set/clear/toggle/hold commands over a valid/ready handshake and buffers them in a small FIFO.
- Plays each command onto registered J/K outputs for a programmable number of cycles, with a fixed idle gap between commands.
- Sits directly in front of the JK flop, with J/K wired straight to its J/K inputs; both blocks share one clock and one reset.

Parameters:
- DEPTH, 4: command FIFO entries. Power of two, 2..16.
- LEN_W, 4: width of cmd_len. Each command is applied for cmd_len+1 cycles, i.e. 1..2^LEN_W.
- GAP_CYC, 1: J=K=0 cycles inserted after each command. 0 means back-to-back commands; allowed range 0..15.

Ports:
- clk, input, 1: rising-edge clock.
- rstn, input, 1: asynchronous reset, active low.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: FIFO can accept a command (= not full).
- cmd_op, input, 2: 00 hold, 01 clear, 10 set, 11 toggle.
- cmd_len, input, LEN_W: apply duration minus one.
- J, output, 1: registered, drives the flop's J input.
- K, output, 1: registered, drives the flop's K input.
- done, output, 1: one-cycle pulse during the last apply cycle of each command.
- busy, output, 1: FSM not IDLE or FIFO not empty.
- q_fb, input, 1: flop Q feedback. Present only with JK_CHECK_EN.
- err, output, 1: sticky mismatch flag. Present only with JK_CHECK_EN.

Behaviour:
- Reset (async, rstn=0):
  - FIFO emptied; FSM goes to IDLE; counters cleared.
  - J=0, K=0, done=0, busy=0, err=0; cmd_ready=1 once reset is released.
  - Reset mid-command aborts the command immediately, and J/K drop to 0 asynchronously.
- Handshake:
  - A command is accepted in any cycle where cmd_valid=1 and cmd_ready=1; it is written at the end of that cycle.
  - When full, cmd_ready=0 and there is no push-through, even if a pop happens in the same cycle.
  - cmd_op and cmd_len are don't-care while cmd_valid=0.
- Op mapping to J/K: hold = 0/0, clear = 0/1, set = 1/0, toggle = 1/1.
- FSM states: IDLE, APPLY, GAP.
  - IDLE: J=K=0. If the FIFO is non-empty, pop the head, load J/K from its op, load len_cnt=cmd_len, go to APPLY.
  - APPLY: J/K held; len_cnt decrements each cycle.
    - done=1 in the cycle where len_cnt==0.
    - After that cycle: if GAP_CYC>0, go to GAP with J=K=0 and gap_cnt=GAP_CYC-1.
    - Else if the FIFO is non-empty, pop the next command and stay in APPLY. J/K change without a gap.
    - Else go to IDLE with J=K=0.
  - GAP: J=K=0. When gap_cnt==0, pop and go to APPLY if the FIFO is non-empty, else go to IDLE.
- Latency: a command accepted in cycle C, with the FIFO empty and FSM in IDLE, drives J/K in cycles C+2 .. C+2+cmd_len.
- FIFO: circular buffer with read/write pointers that wrap modulo DEPTH, plus a count of width log2(DEPTH)+1.
  - A simultaneous push and pop leaves the count unchanged.
- A toggle with cmd_len=k toggles Q k+1 times (one per cycle); this is intended.

Optional Feature:
- Macro: JK_CHECK_EN.
- Defined:
  - Internal model q_exp resets to 0 and updates each cycle using JK rules from the registered J/K.
  - q_fb is compared to q_exp every cycle after reset release.
  - Any mismatch sets err, which stays set until rstn.
- Undefined: q_fb and err ports are absent; no checker logic is built.

Decomposition:
- Shared package: JK_OP_HOLD/CLEAR/SET/TOGGLE 2-bit constants and the FSM state encodings (IDLE=2'd0, APPLY=2'd1, GAP=2'd2).
- One sub-module: jk_cmd_fifo (parameterised DEPTH, width 2+LEN_W; ports push/pop/full/empty/rdata).
- The FSM stays in the top module.

Test Plan:
- Reset: assert rstn=0 mid-APPLY of a set with cmd_len=5 → J=K=0 and busy=0 immediately; after release, cmd_ready=1 and the FIFO is empty (no stale command replayed).
- Single command: push set, cmd_len=0, in cycle 10 → J=1,K=0 in cycle 12 only; done=1 in cycle 12; J=K=0 from cycle 13; connected flop Q=1 from cycle 13.
- Back-to-back with GAP_CYC=0: push set(len 1), clear(len 0), toggle(len 2) → J/K sequence 10,10,01,11,11,11 with no gap cycles; three done pulses; final Q=1.
- Backpressure (DEPTH=4): hold cmd_valid=1 with long commands (len 15) → cmd_ready deasserts after 5 accepts (1 popped + 4 buffered); no command lost or duplicated; done count equals push count.
- Gap (GAP_CYC=3): two toggle(len 0) commands → J=K=1 for 1 cycle, 0 for 3 cycles, 1 for 1 cycle; busy falls the cycle after the second GAP ends.
- JK_CHECK_EN: force q_fb opposite to q_exp for one cycle after a set → err=1 and stays 1 through further commands until rstn=0.

Source files
------------

// File: rtl/jk_cmd_pkg.sv
// rtl/jk_cmd_pkg.sv - shared op codes, FSM states and JK helpers for jk_cmd_sequencer
package jk_cmd_pkg;

  localparam logic [1:0] JK_OP_HOLD   = 2'b00;
  localparam logic [1:0] JK_OP_CLEAR  = 2'b01;
  localparam logic [1:0] JK_OP_SET    = 2'b10;
  localparam logic [1:0] JK_OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Returns {J, K} for a command op
  function automatic logic [1:0] op_to_jk(input logic [1:0] op);
    logic [1:0] jk;
    jk = 2'b00;
    case (op)
      JK_OP_CLEAR:  jk = 2'b01;
      JK_OP_SET:    jk = 2'b10;
      JK_OP_TOGGLE: jk = 2'b11;
      default:      jk = 2'b00;
    endcase
    return jk;
  endfunction

  // Next Q of a JK flop
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic n;
    n = q;
    case ({j, k})
      2'b01:   n = 1'b0;
      2'b10:   n = 1'b1;
      2'b11:   n = ~q;
      default: n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// rtl/jk_cmd_fifo.sv - circular command buffer with wrap-around pointers and occupancy count
module jk_cmd_fifo import jk_cmd_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // No push-through when full, even if the head is popped this cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - buffered command player driving J/K of a JK flop; JK_CHECK_EN adds a Q checker
module jk_cmd_sequencer import jk_cmd_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             J,
  output logic             K,
  output logic             done,
`ifdef JK_CHECK_EN
  input  logic             q_fb,
  output logic             err,
`endif
  output logic             busy
);

  localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  state_t           state;
  logic [LEN_W-1:0] len_cnt;
  logic [3:0]       gap_cnt;
  logic             full;
  logic             empty;
  logic             pop_req;
  logic [LEN_W+1:0] head;
  logic [1:0]       head_op;
  logic [LEN_W-1:0] head_len;

  assign cmd_ready = !full;
  assign busy      = (state != ST_IDLE) || !empty;
  assign head_op   = head[LEN_W+1:LEN_W];
  assign head_len  = head[LEN_W-1:0];

  // Pop whenever the FSM is about to start a new command and one is waiting
  assign pop_req = !empty && ((state == ST_IDLE) ||
                              (state == ST_APPLY && len_cnt == '0 && GAP_CYC == 0) ||
                              (state == ST_GAP && gap_cnt == '0));

  jk_cmd_fifo #(.DEPTH(DEPTH), .W(LEN_W + 2)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (cmd_valid),
    .wdata ({cmd_op, cmd_len}),
    .pop   (pop_req),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Sequencer FSM with registered J/K/done; reset drops J/K immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      len_cnt <= '0;
      gap_cnt <= '0;
      J       <= 1'b0;
      K       <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop_req) begin
            {J, K}  <= op_to_jk(head_op);
            len_cnt <= head_len;
            done    <= (head_len == '0);
            state   <= ST_APPLY;
          end else begin
            {J, K} <= 2'b00;
            done   <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (len_cnt == '0) begin
            if (GAP_CYC != 0) begin
              {J, K}  <= 2'b00;
              done    <= 1'b0;
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end else if (pop_req) begin
              {J, K}  <= op_to_jk(head_op);
              len_cnt <= head_len;
              done    <= (head_len == '0);
            end else begin
              {J, K} <= 2'b00;
              done   <= 1'b0;
              state  <= ST_IDLE;
            end
          end else begin
            len_cnt <= len_cnt - LEN_W'(1);
            done    <= (len_cnt == LEN_W'(1));
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            if (pop_req) begin
              {J, K}  <= op_to_jk(head_op);
              len_cnt <= head_len;
              done    <= (head_len == '0);
              state   <= ST_APPLY;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          {J, K} <= 2'b00;
          done   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef JK_CHECK_EN
  logic q_exp;

  // Shadow of the downstream flop; any disagreement latches err until reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_exp <= 1'b0;
      err   <= 1'b0;
    end else begin
      q_exp <= jk_next(J, K, q_exp);
      err   <= err | (q_fb != q_exp);
    end
  end
`endif

endmodule
